// File: rtl/riscv_divider_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package riscv_div_pkg;

  typedef enum logic [3:0] {
    DIV_NONE = 4'd0,
    DIV_S    = 4'd1,
    DIV_U    = 4'd2,
    REM_S    = 4'd3,
    REM_U    = 4'd4
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } div_state_e;

  // Signed overflow case: most negative dividend divided by -1.
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

endpackage

// File: rtl/riscv_divider_if.sv
// Start/done request bus between the execute stage and the divider.
interface riscv_divider_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [3:0]      divsel;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;

  modport master (
    output start, divsel, a, b,
    input  busy, done, res
  );

  modport slave (
    input  start, divsel, a, b,
    output busy, done, res
  );
endinterface

// File: rtl/riscv_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r_i,
  input  logic            msb_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] r_o,
  output logic            q_o
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // r < divisor holds between steps, so the top bit of diff is a clean borrow flag
  // even when the shifted remainder spills past XLEN bits.
  assign shifted = {r_i, msb_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = ~diff[XLEN];
  assign r_o     = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/riscv_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with a start/done handshake.
module riscv_divider
  import riscv_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  riscv_divider_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  div_state_e      state_q, state_d;
  logic [XLEN-1:0] dq_q, dq_d;       // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            want_rem_q, want_rem_d;

  logic [XLEN-1:0] step_r;
  logic            step_q;
  logic            op_valid, op_signed, op_rem;

  div_step #(.XLEN(XLEN)) u_step (
    .r_i       (rem_q),
    .msb_i     (dq_q[XLEN-1]),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  assign op_valid  = (bus.divsel >= 4'(DIV_S)) && (bus.divsel <= 4'(REM_U));
  assign op_signed = (bus.divsel == 4'(DIV_S)) || (bus.divsel == 4'(REM_S));
  assign op_rem    = (bus.divsel == 4'(REM_S)) || (bus.divsel == 4'(REM_U));

  always_comb begin
    state_d    = state_q;
    dq_d       = dq_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    want_rem_d = want_rem_q;
    case (state_q)
      IDLE: begin
        if (bus.start && op_valid) begin
          want_rem_d = op_rem;
          if (bus.b == '0) begin
            res_d   = op_rem ? bus.a : '1;
            state_d = DONE;
          end else if (op_signed && (bus.a == OVF_DIVIDEND) && (bus.b == OVF_DIVISOR)) begin
            res_d   = op_rem ? '0 : OVF_DIVIDEND;
            state_d = DONE;
          end else begin
            dq_d    = (op_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
            dvs_d   = (op_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;
            rem_d   = '0;
            cnt_d   = '0;
            neg_q_d = op_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            neg_r_d = op_signed & bus.a[XLEN-1];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_r;
        dq_d  = {dq_q[XLEN-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        res_d   = want_rem_q ? (neg_r_q ? -rem_q : rem_q)
                             : (neg_q_q ? -dq_q : dq_q);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dq_q       <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dq_q       <= dq_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      want_rem_q <= want_rem_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.res  = res_q;
endmodule

// File: tb/tb_riscv_divider.sv
// Directed bench for riscv_divider: vector table plus handshake and reset sequences.
module tb_riscv_divider;
  import riscv_div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  riscv_divider_if #(.XLEN(32)) dif ();

  riscv_divider #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input string n, input logic [3:0] s, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e, input logic f);
    vec_t v;
    v.name = n; v.sel = s; v.a = a; v.b = b; v.exp = e; v.fast = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request, scramble the operands right after acceptance, then
  // measure latency, busy span, the done pulse width and result hold.
  task automatic run_op(input string name, input logic [3:0] sel, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] exp, input logic fast);
    int lat;
    int bc;
    @(negedge clk);
    dif.start = 1'b1; dif.divsel = sel; dif.a = aa; dif.b = bb;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.divsel = 4'd0; dif.a = ~aa; dif.b = bb + 32'd3;
    lat = 0; bc = 0;
    while (dif.done !== 1'b1 && lat < 100) begin
      if (dif.busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
    if (dif.busy === 1'b1) bc++;
    check({name, " res"}, dif.res, exp);
    check({name, " latency"}, 32'(lat), fast ? 32'd0 : 32'd33);
    check({name, " busy_cycles"}, 32'(bc), fast ? 32'd1 : 32'd34);
    @(posedge clk); #1;
    check({name, " done_width"}, {31'd0, dif.done}, 32'd0);
    check({name, " idle_after"}, {31'd0, dif.busy}, 32'd0);
    check({name, " res_hold"}, dif.res, exp);
    $display("[TB] %-12s sel=%0d a=%h b=%h res=%h lat=%0d busy=%0d", name, sel, aa, bb,
             dif.res, lat, bc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;

    vecs[0]  = mk("divu_100_7",  4'd2, 32'd100,       32'd7,          32'd14,         1'b0);
    vecs[1]  = mk("remu_100_7",  4'd4, 32'd100,       32'd7,          32'd2,          1'b0);
    vecs[2]  = mk("rem_m7_2",    4'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF,  1'b0);
    vecs[3]  = mk("div_m7_2",    4'd1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD,  1'b0);
    vecs[4]  = mk("div_100_m7",  4'd1, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0);
    vecs[5]  = mk("rem_100_m7",  4'd3, 32'd100,       32'hFFFF_FFF9,  32'd2,          1'b0);
    vecs[6]  = mk("div_min_3",   4'd1, 32'h8000_0000, 32'd3,          32'hD555_5556,  1'b0);
    vecs[7]  = mk("rem_min_3",   4'd3, 32'h8000_0000, 32'd3,          32'hFFFF_FFFE,  1'b0);
    vecs[8]  = mk("divu_big",    4'd2, 32'hFFFF_FFFF, 32'h8000_0001,  32'd1,          1'b0);
    vecs[9]  = mk("remu_big",    4'd4, 32'hFFFF_FFFF, 32'h8000_0001,  32'h7FFF_FFFE,  1'b0);
    vecs[10] = mk("divu_min_m1", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1'b0);
    vecs[11] = mk("div_5_0",     4'd1, 32'd5,         32'd0,          32'hFFFF_FFFF,  1'b1);
    vecs[12] = mk("remu_5_0",    4'd4, 32'd5,         32'd0,          32'd5,          1'b1);
    vecs[13] = mk("rem_m7_0",    4'd3, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9,  1'b1);
    vecs[14] = mk("divu_0_0",    4'd2, 32'd0,         32'd0,          32'hFFFF_FFFF,  1'b1);
    vecs[15] = mk("div_ovf",     4'd1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
    vecs[16] = mk("rem_ovf",     4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1'b1);
    vecs[17] = mk("div_m1_m1",   4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,          1'b0);

    dif.start = 1'b0; dif.divsel = 4'd0; dif.a = '0; dif.b = '0;

    // Reset state while rst is held low.
    #12;
    check("reset busy", {31'd0, dif.busy}, 32'd0);
    check("reset done", {31'd0, dif.done}, 32'd0);
    check("reset res",  dif.res, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    $display("[TB] reset released");

    // Invalid selections must not start an operation.
    foreach (vecs[i]) begin
      if (i < 3) begin
        @(negedge clk);
        dif.start = 1'b1; dif.divsel = (i == 0) ? 4'd0 : (i == 1) ? 4'd7 : 4'd15;
        dif.a = 32'd9; dif.b = 32'd3;
        @(posedge clk); #1;
        check("bad_sel busy", {31'd0, dif.busy}, 32'd0);
        check("bad_sel done", {31'd0, dif.done}, 32'd0);
        dif.start = 1'b0;
        $display("[TB] ignored start with divsel=%0d busy=%b", dif.divsel, dif.busy);
      end
    end

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast);
    end

    // A second start while CALC is running is ignored.
    @(negedge clk);
    dif.start = 1'b1; dif.divsel = 4'd2; dif.a = 32'd100; dif.b = 32'd7;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    dif.start = 1'b1; dif.divsel = 4'd1; dif.a = 32'd1000; dif.b = 32'd3;
    @(negedge clk);
    dif.start = 1'b0;
    wait_cnt = 0;
    while (dif.done !== 1'b1 && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("restart res", dif.res, 32'd14);
    check("restart done_seen", {31'd0, dif.done}, 32'd1);
    @(posedge clk); #1;
    check("restart idle", {31'd0, dif.busy}, 32'd0);
    $display("[TB] restart_in_calc res=%h", dif.res);

    // Asynchronous reset in the middle of CALC (count = 10).
    @(negedge clk);
    dif.start = 1'b1; dif.divsel = 4'd2; dif.a = 32'd1000; dif.b = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("midreset busy_before", {31'd0, dif.busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midreset busy", {31'd0, dif.busy}, 32'd0);
    check("midreset done", {31'd0, dif.done}, 32'd0);
    check("midreset res",  dif.res, 32'd0);
    wait_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dif.done === 1'b1) wait_cnt++;
    end
    check("midreset no_done", 32'(wait_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] mid-calc reset res=%h busy=%b", dif.res, dif.busy);
    run_op("post_reset", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
